// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the MCU stream reader.
//   MCU_DIM / MCU_WORDS : geometry of one MCU (8x8 coefficients)
//   ZIGZAG              : JPEG zigzag scan, position -> raster index (row*8+col)
//   coef_t              : coefficient word at the default width; modules with a
//                         different COEF_W declare their own word type
//   state_t             : reader FSM states
package mcu_pkg;

  localparam int MCU_DIM    = 8;
  localparam int MCU_WORDS  = MCU_DIM * MCU_DIM;
  localparam int DEF_COEF_W = 32;

  typedef logic [DEF_COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  localparam logic [5:0] ZIGZAG [MCU_WORDS] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

endpackage

// File: rtl/mcu_stream_reader_if.sv
// mcu_stream_reader_if: coefficient stream from the reader to its consumer.
//   out_valid/out_ready : handshake
//   out_data            : coefficient
//   out_mcu             : MCU index of the beat
//   out_row/out_col     : position of the coefficient inside its MCU
//   out_last            : final beat of the run
//
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, with all payload
// fields (out_data, out_mcu, out_row, out_col, out_last) stable, until that
// transfer. out_valid never depends combinationally on out_ready.
interface mcu_stream_reader_if #(
  parameter int COEF_W = 32,
  parameter int IDX_W  = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [COEF_W-1:0] out_data;
  logic [IDX_W-1:0]  out_mcu;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_mcu, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_mcu, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/mcu_order_gen.sv
// mcu_order_gen: maps a scan position to the raster index of the coefficient
// emitted at that position.
//   pos    : scan position 0..63
//   zigzag : 0 = raster scan, 1 = JPEG zigzag scan
//   idx    : raster index row*8+col
//   row/col: idx split into its row and column
module mcu_order_gen
  import mcu_pkg::*;
(
  input  logic [5:0] pos,
  input  logic       zigzag,
  output logic [5:0] idx,
  output logic [2:0] row,
  output logic [2:0] col
);

  assign idx = zigzag ? ZIGZAG[pos] : pos;
  assign row = idx[5:3];
  assign col = idx[2:0];

endmodule

// File: rtl/mcu_stream_reader.sv
// mcu_stream_reader: walks a run of consecutive MCUs and streams their
// coefficients, one per beat, in raster or zigzag order.
//   clk, reset         : clock, synchronous active-high reset
//   mcu_in             : all MCUs, indexed [mcu][row][col]
//   start              : run request, only looked at while idle
//   start_idx, count   : first MCU and number of MCUs in the run
//   zigzag             : scan order for the run (latched at start)
//   busy               : high whenever not idle
//   err                : one-cycle pulse after a rejected start
//   done               : one-cycle pulse after the final beat
//   dbg_state          : current FSM state
//   stream             : coefficient stream (master side)
module mcu_stream_reader
  import mcu_pkg::*;
#(
  parameter int N_MCU  = 28,
  parameter int COEF_W = 32,
  parameter int IDX_W  = (N_MCU > 1) ? $clog2(N_MCU) : 1
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [N_MCU-1:0][MCU_DIM-1:0][MCU_DIM-1:0][COEF_W-1:0] mcu_in,
  input  logic                                               start,
  input  logic [IDX_W-1:0]                                   start_idx,
  input  logic [IDX_W:0]                                     count,
  input  logic                                               zigzag,
  output logic                                               busy,
  output logic                                               err,
  output logic                                               done,
  output state_t                                             dbg_state,
  mcu_stream_reader_if.master                                stream
);

  localparam logic [IDX_W+1:0] N_MCU_W = (IDX_W+2)'(N_MCU);
  localparam logic [IDX_W:0]   LEFT_ONE = (IDX_W+1)'(1);

  state_t                             state;
  logic [MCU_WORDS-1:0][COEF_W-1:0]   shadow;
  logic [5:0]                         pos;
  logic [IDX_W-1:0]                   cur;
  logic [IDX_W:0]                     left;
  logic                               zz;

  logic [5:0]                         idx;
  logic [2:0]                         row;
  logic [2:0]                         col;
  logic [IDX_W+1:0]                   end_sum;
  logic                               legal;
  logic                               streaming;

  // Range check done two bits wider than the index so start_idx + count
  // cannot wrap back into the legal range.
  assign end_sum = {2'b00, start_idx} + {1'b0, count};
  assign legal   = (count != '0) && ({2'b00, start_idx} < N_MCU_W) && (end_sum <= N_MCU_W);

  mcu_order_gen u_order (
    .pos    (pos),
    .zigzag (zz),
    .idx    (idx),
    .row    (row),
    .col    (col)
  );

  // The shadow copy decouples the stream from mcu_in: the MCU is captured in
  // LOAD and the storage upstream may change freely while it is streamed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err   <= 1'b0;
      pos   <= '0;
      cur   <= '0;
      left  <= '0;
      zz    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              cur   <= start_idx;
              left  <= count;
              zz    <= zigzag;
              state <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          shadow <= mcu_in[cur];
          pos    <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          if (stream.out_ready) begin
            if (pos != 6'd63) begin
              pos <= pos + 6'd1;
            end else if (left == LEFT_ONE) begin
              state <= DONE;
            end else begin
              cur   <= cur + (IDX_W)'(1);
              left  <= left - LEFT_ONE;
              state <= LOAD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status and stream outputs are decoded from registered state only, so
  // nothing here depends combinationally on out_ready. Payload is forced to
  // zero outside STREAM, which also gives the zero reset values.
  assign streaming        = (state == STREAM);
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign dbg_state        = state;
  assign stream.out_valid = streaming;
  assign stream.out_last  = streaming && (pos == 6'd63) && (left == LEFT_ONE);
  assign stream.out_data  = streaming ? shadow[idx] : '0;
  assign stream.out_mcu   = streaming ? cur : '0;
  assign stream.out_row   = streaming ? row : '0;
  assign stream.out_col   = streaming ? col : '0;

endmodule

// File: tb/tb_mcu_stream_reader.sv
// tb_mcu_stream_reader: bench for mcu_stream_reader and mcu_order_gen.
module tb_mcu_stream_reader;
  import mcu_pkg::*;

  localparam int N_MCU  = 28;
  localparam int COEF_W = 32;
  localparam int IDX_W  = 5;
  localparam int BW     = 1 + IDX_W + 3 + 3 + COEF_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic [N_MCU-1:0][7:0][7:0][COEF_W-1:0] mcu_in;
  logic             start     = 1'b0;
  logic [IDX_W-1:0] start_idx = '0;
  logic [IDX_W:0]   count     = '0;
  logic             zigzag    = 1'b0;
  logic             busy, err, done;
  state_t           dbg_state;

  mcu_stream_reader_if #(.COEF_W(COEF_W), .IDX_W(IDX_W)) stream ();

  mcu_stream_reader #(.N_MCU(N_MCU), .COEF_W(COEF_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mcu_in    (mcu_in),
    .start     (start),
    .start_idx (start_idx),
    .count     (count),
    .zigzag    (zigzag),
    .busy      (busy),
    .err       (err),
    .done      (done),
    .dbg_state (dbg_state),
    .stream    (stream)
  );

  logic [5:0] og_pos = '0;
  logic       og_zz  = 1'b0;
  logic [5:0] og_idx;
  logic [2:0] og_row, og_col;

  mcu_order_gen u_og (
    .pos    (og_pos),
    .zigzag (og_zz),
    .idx    (og_idx),
    .row    (og_row),
    .col    (og_col)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Zigzag scan built by walking the anti-diagonals, alternating direction.
  int zz_r[64];
  int zz_c[64];

  task automatic build_zz();
    int p, r, c;
    p = 0;
    for (int s = 0; s < 15; s++) begin
      for (int k = 0; k < 8; k++) begin
        if (s % 2 == 0) r = ((s < 8) ? s : 7) - k;
        else            r = ((s < 8) ? 0 : s - 7) + k;
        c = s - r;
        if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
          zz_r[p] = r;
          zz_c[p] = c;
          p++;
        end
      end
    end
  endtask

  // beat = {last, mcu, row, col, data}
  logic [BW-1:0] exp_q[$];

  task automatic push_run(int idx, int cnt, bit zz);
    int r, c;
    logic last;
    for (int m = idx; m < idx + cnt; m++) begin
      for (int p = 0; p < 64; p++) begin
        r = zz ? zz_r[p] : p / 8;
        c = zz ? zz_c[p] : p % 8;
        last = (m == idx + cnt - 1) && (p == 63);
        exp_q.push_back({last, IDX_W'(m), 3'(r), 3'(c), mcu_in[m][r][c]});
      end
    end
  endtask

  // ---------------- ready driver ----------------
  int rmode = 0;  // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  int pat   = 0;
  initial begin
    stream.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: stream.out_ready = 1'b1;
        1: begin
          stream.out_ready = (pat % 4 == 0) || (pat % 4 == 3);
          pat++;
        end
        default: stream.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int            beats, n_done, n_err;
  int            first_valid_cyc, done_cyc, err_cyc;
  bit            valid_seen, busy_seen;
  bit            stalled = 1'b0;
  logic [BW-1:0] stall_val, exp_b, now_b;
  logic [BW-1:0] got[192];

  initial begin
    forever begin
      @(negedge clk);
      now_b = {stream.out_last, stream.out_mcu, stream.out_row, stream.out_col, stream.out_data};
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid_held", 64'(stream.out_valid), 64'd1);
          chk("stall_payload_held", 64'(now_b), 64'(stall_val));
        end
        if (busy) busy_seen = 1'b1;
        if (stream.out_valid && !valid_seen) begin
          first_valid_cyc = cyc;
          valid_seen = 1'b1;
        end
        if (err) begin
          n_err++;
          err_cyc = cyc;
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        stalled = stream.out_valid && !stream.out_ready;
        stall_val = now_b;
        if (stream.out_valid && stream.out_ready) begin
          if (beats < 192) got[beats] = now_b;
          beats++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL extra_beat: got beat 0x%0h, expected no beat", now_b);
          end else begin
            exp_b = exp_q.pop_front();
            chk("beat", 64'(now_b), 64'(exp_b));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int s_cyc;

  task automatic start_req(int idx, int cnt, bit zz);
    @(posedge clk);
    #1;
    beats = 0; n_done = 0; n_err = 0;
    first_valid_cyc = -1; done_cyc = -1; err_cyc = -1;
    valid_seen = 1'b0; busy_seen = 1'b0;
    start = 1'b1;
    start_idx = IDX_W'(idx);
    count = (IDX_W+1)'(cnt);
    zigzag = zz;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int limit);
    int n;
    n = 0;
    while (n_done == 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (n_done == 0) begin
      n_checks++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic finish_run(int cnt);
    chk("beats_left_in_queue", 64'(exp_q.size()), 64'd0);
    chk("beat_count", 64'(beats), 64'(64 * cnt));
    chk("done_pulses", 64'(n_done), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_run(int idx, int cnt, bit zz, int mode, bit check_time);
    rmode = mode;
    push_run(idx, cnt, zz);
    start_req(idx, cnt, zz);
    wait_done(400 * cnt + 50);
    chk("first_valid_cycle", 64'(first_valid_cyc), 64'(s_cyc + 2));
    if (check_time) chk("done_cycle", 64'(done_cyc), 64'(s_cyc + 65 * cnt + 1));
    finish_run(cnt);
  endtask

  task automatic do_illegal(int idx, int cnt);
    start_req(idx, cnt, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_pulses", 64'(n_err), 64'd1);
    chk("err_cycle", 64'(err_cyc), 64'(s_cyc + 1));
    chk("illegal_no_valid", 64'(valid_seen), 64'd0);
    chk("illegal_no_busy", 64'(busy_seen), 64'd0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [5:0] pos;
    logic       zz;
    logic [5:0] idx;
    logic [2:0] row;
    logic [2:0] col;
  } og_vec_t;

  typedef struct {
    int idx;
    int cnt;
    bit zz;
    int mode;
    bit legal;
  } req_t;

  og_vec_t og_tab[8];
  req_t    reqs[9];

  int ridx, rcnt;
  bit rzz;
  int zz_first[6];

  initial begin
    build_zz();

    og_tab[0] = '{6'd0,  1'b1, 6'd0,  3'd0, 3'd0};
    og_tab[1] = '{6'd1,  1'b1, 6'd1,  3'd0, 3'd1};
    og_tab[2] = '{6'd2,  1'b1, 6'd8,  3'd1, 3'd0};
    og_tab[3] = '{6'd3,  1'b1, 6'd16, 3'd2, 3'd0};
    og_tab[4] = '{6'd4,  1'b1, 6'd9,  3'd1, 3'd1};
    og_tab[5] = '{6'd5,  1'b1, 6'd2,  3'd0, 3'd2};
    og_tab[6] = '{6'd63, 1'b1, 6'd63, 3'd7, 3'd7};
    og_tab[7] = '{6'd13, 1'b0, 6'd13, 3'd1, 3'd5};

    //           idx cnt zz mode legal
    reqs[0] = '{  3,  1, 0, 0, 1};
    reqs[1] = '{ 27,  2, 0, 0, 0};
    reqs[2] = '{  0,  0, 0, 0, 0};
    reqs[3] = '{ 28,  1, 0, 0, 0};
    reqs[4] = '{ 27,  1, 1, 2, 1};
    reqs[5] = '{ 31,  1, 0, 0, 0};
    reqs[6] = '{  2, 27, 0, 0, 0};
    reqs[7] = '{  1, 27, 1, 0, 1};
    reqs[8] = '{ 10,  4, 0, 2, 1};

    zz_first = '{0, 1, 100, 200, 101, 2};

    for (int m = 0; m < N_MCU; m++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          mcu_in[m][r][c] = (m == 3) ? COEF_W'(100 * r + c) : $urandom;

    // order generator in isolation
    for (int i = 0; i < 8; i++) begin
      og_pos = og_tab[i].pos;
      og_zz  = og_tab[i].zz;
      #1;
      chk("order_gen_table", 64'({og_idx, og_row, og_col}),
          64'({og_tab[i].idx, og_tab[i].row, og_tab[i].col}));
    end
    for (int p = 0; p < 64; p++) begin
      og_pos = 6'(p);
      og_zz  = 1'b1;
      #1;
      chk("order_gen_zigzag", 64'({og_row, og_col}), 64'({3'(zz_r[p]), 3'(zz_c[p])}));
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", 64'({busy, err, done, stream.out_valid, stream.out_last}), 64'd0);
    chk("reset_payload", 64'({stream.out_data, stream.out_mcu, stream.out_row, stream.out_col}), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;

    // table of requests
    for (int i = 0; i < 9; i++) begin
      if (reqs[i].legal) do_run(reqs[i].idx, reqs[i].cnt, reqs[i].zz, reqs[i].mode, reqs[i].mode == 0);
      else               do_illegal(reqs[i].idx, reqs[i].cnt);
    end

    // single MCU raster: values and last flag
    do_run(3, 1, 1'b0, 0, 1'b1);
    chk("raster_beat_1", 64'(got[1][COEF_W-1:0]), 64'd1);
    chk("raster_beat_8", 64'(got[8][COEF_W-1:0]), 64'd100);
    chk("raster_last_beat", 64'(got[63]), 64'({1'b1, 5'd3, 3'd7, 3'd7, 32'd707}));
    chk("raster_not_last", 64'(got[62][BW-1]), 64'd0);

    // zigzag: first six beats and final beat
    do_run(3, 1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      chk("zigzag_first_six", 64'(got[i][COEF_W-1:0]), 64'(zz_first[i]));
    chk("zigzag_last_beat", 64'(got[63]), 64'({1'b1, 5'd3, 3'd7, 3'd7, 32'd707}));

    // multi-MCU run with 1,0,0,1 backpressure
    pat = 0;
    do_run(25, 3, 1'b0, 1, 1'b0);
    chk("bp_mcu_first", 64'(got[0][COEF_W+6 +: IDX_W]), 64'd25);
    chk("bp_mcu_second", 64'(got[64][COEF_W+6 +: IDX_W]), 64'd26);
    chk("bp_mcu_third", 64'(got[191][COEF_W+6 +: IDX_W]), 64'd27);

    // input isolation and ignored start
    rmode = 0;
    push_run(5, 1, 1'b0);
    start_req(5, 1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mcu_in[5][r][c] = 32'hdead0000 | COEF_W'(8 * r + c);
    start = 1'b1;
    start_idx = 5'd0;
    count = 6'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(300);
    chk("isolation_err", 64'(n_err), 64'd0);
    finish_run(1);
    valid_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ignored_start_no_valid", 64'(valid_seen), 64'd0);
    chk("ignored_start_no_busy", 64'(busy_seen), 64'd0);

    // reset in the middle of a 2-MCU run
    rmode = 0;
    push_run(10, 2, 1'b0);
    start_req(10, 2, 1'b0);
    for (int n = 0; n < 500 && beats < 30; n++) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset_status", 64'({busy, err, done, stream.out_valid, stream.out_last}), 64'd0);
    chk("midrun_reset_payload", 64'({stream.out_data, stream.out_mcu, stream.out_row, stream.out_col}), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    do_run(10, 2, 1'b0, 0, 1'b1);
    chk("after_reset_pos0", 64'(got[0][COEF_W +: 6]), 64'd0);

    // randomized requests against the model
    for (int t = 0; t < 8; t++) begin
      for (int m = 0; m < N_MCU; m++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            mcu_in[m][r][c] = $urandom;
      ridx = $urandom_range(0, 31);
      rcnt = $urandom_range(0, 4);
      rzz  = 1'($urandom_range(0, 1));
      if (rcnt >= 1 && ridx + rcnt <= N_MCU) do_run(ridx, rcnt, rzz, 2, 1'b0);
      else                                   do_illegal(ridx, rcnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
